// File: rtl/reg_bank_arbiter_if.sv
// reg_bank_arbiter_if
//   Bundles the two write requesters, their grants, the read port and the
//   status outputs of reg_bank_arbiter.
//   master : drives req/addr/data for both requesters and rd_addr
//   slave  : the arbiter; drives gnt0/gnt1, busy, rd_data, wr_count
interface reg_bank_arbiter_if;
    logic       req0;
    logic [1:0] addr0;
    logic [7:0] data0;
    logic       req1;
    logic [1:0] addr1;
    logic [7:0] data1;
    logic       gnt0;
    logic       gnt1;
    logic       busy;
    logic [1:0] rd_addr;
    logic [7:0] rd_data;
    logic [7:0] wr_count;

    modport master (
        output req0, addr0, data0, req1, addr1, data1, rd_addr,
        input  gnt0, gnt1, busy, rd_data, wr_count
    );

    modport slave (
        input  req0, addr0, data0, req1, addr1, data1, rd_addr,
        output gnt0, gnt1, busy, rd_data, wr_count
    );
endinterface

// File: rtl/reg_bank_arbiter.sv
// reg_bank_arbiter
//   Four 8-bit registers shared by two write requesters. A write is committed
//   at the IDLE edge where a request is seen; the grant is the registered
//   acknowledge of that commit and lasts exactly one cycle (ACK state), during
//   which all requests are ignored. Contention is resolved round-robin,
//   requester 0 first after reset.
//   Ports:
//     clk  : system clock, rising edge
//     clr  : synchronous active-high reset
//     bus  : reg_bank_arbiter_if.slave (requests, grants, read port, status)
module reg_bank_arbiter #(
    parameter logic [7:0] RESET_VAL = 8'h00
) (
    input  logic                 clk,
    input  logic                 clr,
    reg_bank_arbiter_if.slave    bus
);

    typedef enum logic {IDLE, ACK} state_t;

    state_t          state;
    state_t          state_nxt;
    logic [3:0][7:0] regs;
    logic            prio;      // requester that wins the next contention
    logic            gnt0_q;
    logic            gnt1_q;
    logic [7:0]      count;

    logic            wr_en;
    logic            win;       // 0: requester 0, 1: requester 1
    logic [1:0]      wr_addr;
    logic [7:0]      wr_data;

    always_comb begin
        state_nxt = state;
        wr_en     = 1'b0;
        win       = 1'b0;
        case (state)
            IDLE: begin
                if (bus.req0 && bus.req1) begin
                    wr_en     = 1'b1;
                    win       = prio;
                    state_nxt = ACK;
                end else if (bus.req0) begin
                    wr_en     = 1'b1;
                    win       = 1'b0;
                    state_nxt = ACK;
                end else if (bus.req1) begin
                    wr_en     = 1'b1;
                    win       = 1'b1;
                    state_nxt = ACK;
                end
            end
            ACK:     state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    assign wr_addr = win ? bus.addr1 : bus.addr0;
    assign wr_data = win ? bus.data1 : bus.data0;

    always_ff @(posedge clk) begin
        if (clr) begin
            state  <= IDLE;
            gnt0_q <= 1'b0;
            gnt1_q <= 1'b0;
            regs   <= {4{RESET_VAL}};
            count  <= 8'h00;
            prio   <= 1'b0;
        end else begin
            state  <= state_nxt;
            gnt0_q <= wr_en & ~win;
            gnt1_q <= wr_en & win;
            if (wr_en) begin
                regs[wr_addr] <= wr_data;
                // loser of this round (or the idle side) is favoured next time
                prio          <= ~win;
                if (count != 8'hFF)
                    count <= count + 8'd1;
            end
        end
    end

    assign bus.gnt0     = gnt0_q;
    assign bus.gnt1     = gnt1_q;
    assign bus.busy     = (state == ACK);
    assign bus.rd_data  = regs[bus.rd_addr];
    assign bus.wr_count = count;

endmodule

// File: tb/tb_reg_bank_arbiter.sv
// tb_reg_bank_arbiter
//   Scoreboard bench: each expected grant (requester, address, data, cycle) is
//   queued when stimulus is driven and checked when the grant appears.
module tb_reg_bank_arbiter;

    typedef struct {
        logic       id;
        logic [1:0] addr;
        logic [7:0] data;
        int         due;
    } exp_t;

    logic clk = 1'b0;
    logic clr = 1'b1;
    int   cyc = 0;
    int   n_tot = 0;
    int   n_bad = 0;

    exp_t       sb[$];
    logic [7:0] m_reg [4];
    int         m_cnt;
    logic       pprio;

    reg_bank_arbiter_if bus();

    reg_bank_arbiter #(.RESET_VAL(8'h00)) dut (
        .clk (clk),
        .clr (clr),
        .bus (bus)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tot++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic push(input logic id, input logic [1:0] addr, input logic [7:0] data, input int due);
        exp_t e;
        e.id = id; e.addr = addr; e.data = data; e.due = due;
        sb.push_back(e);
        pprio = ~id;
    endtask

    // present the next queued write for a requester, or drop its request
    task automatic reload(input logic id);
        bit found = 0;
        foreach (sb[i]) begin
            if (!found && sb[i].id == id) begin
                found = 1;
                if (id) begin bus.req1 = 1'b1; bus.addr1 = sb[i].addr; bus.data1 = sb[i].data; end
                else    begin bus.req0 = 1'b1; bus.addr0 = sb[i].addr; bus.data0 = sb[i].data; end
            end
        end
        if (!found) begin
            if (id) bus.req1 = 1'b0;
            else    bus.req0 = 1'b0;
        end
    endtask

    task automatic run_sb(input int budget);
        int n = 0;
        exp_t e;
        while (sb.size() > 0 && n < budget) begin
            @(posedge clk); #1; n++;
            chk("one_hot", {31'd0, bus.gnt0 & bus.gnt1}, 0);
            if (bus.gnt0 || bus.gnt1) begin
                e = sb.pop_front();
                chk("gnt_id", {31'd0, bus.gnt1}, {31'd0, e.id});
                chk("gnt_cyc", cyc, e.due);
                chk("busy_ack", {31'd0, bus.busy}, 1);
                m_reg[e.addr] = e.data;
                if (m_cnt != 255) m_cnt++;
                bus.rd_addr = e.addr; #1;
                chk("rd_data", {24'd0, bus.rd_data}, {24'd0, m_reg[e.addr]});
                chk("wr_count", {24'd0, bus.wr_count}, m_cnt);
                reload(e.id);
            end else begin
                chk("busy_idle", {31'd0, bus.busy}, 0);
            end
        end
        chk("sb_timeout", sb.size(), 0);
        sb.delete();
    endtask

    task automatic idle_chk();
        @(posedge clk); #1;
        chk("idle_gnt", {30'd0, bus.gnt1, bus.gnt0}, 0);
        chk("idle_busy", {31'd0, bus.busy}, 0);
    endtask

    // clr for one edge; state checked while clr is still high
    task automatic do_clr();
        clr = 1'b1;
        @(posedge clk); #1;
        foreach (m_reg[i]) m_reg[i] = 8'h00;
        m_cnt = 0;
        pprio = 1'b0;
        sb.delete();
        chk("rst_gnt", {30'd0, bus.gnt1, bus.gnt0}, 0);
        chk("rst_busy", {31'd0, bus.busy}, 0);
        chk("rst_cnt", {24'd0, bus.wr_count}, 0);
        for (int a = 0; a < 4; a++) begin
            bus.rd_addr = a[1:0]; #1;
            chk("rst_rd", {24'd0, bus.rd_data}, 0);
        end
        bus.req0 = 1'b0;
        bus.req1 = 1'b0;
        clr = 1'b0;
    endtask

    initial begin
        logic [1:0] a [2];
        logic [7:0] d [2];
        logic       w;
        int         mode;

        bus.req0 = 0; bus.addr0 = 0; bus.data0 = 0;
        bus.req1 = 0; bus.addr1 = 0; bus.data1 = 0;
        bus.rd_addr = 0;
        do_clr();

        // single write, zero-latency grant
        push(1'b0, 2'd2, 8'hFF, cyc + 1);
        reload(1'b0);
        run_sb(10);
        idle_chk();

        // contention right after reset on the same register
        do_clr();
        push(1'b0, 2'd1, 8'hAA, cyc + 1);
        push(1'b1, 2'd1, 8'h55, cyc + 3);
        reload(1'b0); reload(1'b1);
        run_sb(10);
        bus.rd_addr = 2'd1; #1;
        chk("r1_final", {24'd0, bus.rd_data}, 32'h55);
        chk("cnt_two", {24'd0, bus.wr_count}, 2);
        idle_chk();

        // both held for 8 cycles: strict alternation every other cycle
        w = pprio;
        push(w,  2'd0, 8'h11, cyc + 1);
        push(~w, 2'd3, 8'h22, cyc + 3);
        push(w,  2'd2, 8'h33, cyc + 5);
        push(~w, 2'd0, 8'h44, cyc + 7);
        reload(1'b0); reload(1'b1);
        run_sb(12);
        idle_chk();

        // random single and contended writes
        for (int it = 0; it < 10; it++) begin
            mode = $urandom_range(0, 2);
            for (int k = 0; k < 2; k++) begin
                a[k] = 2'($urandom_range(0, 3));
                d[k] = 8'($urandom_range(0, 255));
            end
            if (mode < 2) begin
                push(mode[0], a[mode], d[mode], cyc + 1);
            end else begin
                w = pprio;
                push(w,  a[w],  d[w],  cyc + 1);
                push(~w, a[~w], d[~w], cyc + 3);
            end
            reload(1'b0); reload(1'b1);
            run_sb(12);
            idle_chk();
        end

        // clr during the ACK cycle of a requester-1 write
        do_clr();
        push(1'b1, 2'd3, 8'h3C, cyc + 1);
        reload(1'b1);
        run_sb(10);
        do_clr();
        bus.rd_addr = 2'd3; #1;
        chk("r3_cleared", {24'd0, bus.rd_data}, 0);

        // write presented at the same edge as clr is discarded
        bus.req0 = 1'b1; bus.addr0 = 2'd0; bus.data0 = 8'h5A;
        do_clr();
        idle_chk();
        bus.rd_addr = 2'd0; #1;
        chk("clr_discard", {24'd0, bus.rd_data}, 0);

        // wr_count saturation
        for (int i = 0; i < 300; i++) begin
            push(1'b0, 2'(i), 8'(i), cyc + 1);
            reload(1'b0);
            run_sb(6);
            @(posedge clk); #1;
        end
        chk("cnt_sat", {24'd0, bus.wr_count}, 32'hFF);

        $display("test done: total=%0d bad=%0d", n_tot, n_bad);
        $finish;
    end

endmodule

// File: doc/reg_bank_arbiter.md
REG_BANK_ARBITER -- requirements
Module: reg_bank_arbiter

Interface
REQ-001 Parameter RESET_VAL, default 8'h00, value loaded into every bank register on clr.
REQ-002 clk  input  1  single system clock; all state changes on rising edge.
REQ-003 clr  input  1  reset, synchronous, active-high.
REQ-004 req0  input  1  requester 0 write request; held high until gnt0 seen.
REQ-005 addr0  input  2  requester 0 target register index.
REQ-006 data0  input  8  requester 0 write data.
REQ-007 req1  input  1  requester 1 write request; same rules as req0.
REQ-008 addr1  input  2  requester 1 target register index.
REQ-009 data1  input  8  requester 1 write data.
REQ-010 gnt0  output  1  registered one-cycle acknowledge: requester 0 write committed.
REQ-011 gnt1  output  1  registered one-cycle acknowledge: requester 1 write committed.
REQ-012 busy  output  1  high while controller is in ACK state.
REQ-013 rd_addr  input  2  read port register index.
REQ-014 rd_data  output  8  contents of bank register rd_addr.
REQ-015 wr_count  output  8  number of committed writes since reset, saturating.

Function
REQ-016 Block SHALL contain four 8-bit registers r0..r3 shared by two requesters.
REQ-017 FSM SHALL have two states: IDLE and ACK.
REQ-018 IDLE, no req: SHALL stay IDLE, no write, gnt0=gnt1=0.
REQ-019 IDLE, exactly one reqN high: SHALL write dataN into r[addrN] at that edge, assert gntN, go to ACK.
REQ-020 IDLE, both req high: SHALL grant the requester not granted last (round-robin pointer), write only winner's data, go to ACK.
REQ-021 Round-robin pointer SHALL update only on a grant and SHALL indicate requester 0 as first winner after reset.
REQ-022 ACK: gntN high exactly one cycle, busy=1, all req inputs ignored, no writes; next state always IDLE.
REQ-023 Requester SHALL drop req at the edge ending its gnt cycle; req still high in IDLE afterward is a new request.
REQ-024 Loser of contention SHALL keep req high and SHALL be granted in the IDLE cycle after ACK.
REQ-025 Write throughput SHALL be one write per two cycles max; write-to-gnt latency zero cycles after the committing edge.
REQ-026 Both requesters addressing same register: only winner's data written; loser's write follows in a later grant.
REQ-027 rd_data SHALL be combinational from r[rd_addr]; new value visible the cycle after the committing edge.
REQ-028 wr_count SHALL increment by 1 on each committed write and hold at 8'hFF.
REQ-029 gnt0 and gnt1 SHALL never be high in the same cycle.

Reset
REQ-030 clr high at an edge SHALL force: state IDLE, gnt0=gnt1=0, busy=0, r0..r3=RESET_VAL, wr_count=0, pointer to requester-0-first.
REQ-031 clr SHALL dominate any pending req or ACK state; a write presented at the same edge as clr SHALL be discarded.
REQ-032 With clr high, rd_data SHALL read RESET_VAL after the first edge.

Verification
REQ-033 clr=1 one edge, then rd_addr 0..3 -> rd_data=8'h00 each, wr_count=0, gnt0=gnt1=busy=0.
REQ-034 req0=1, addr0=2, data0=8'hFF in IDLE -> next cycle gnt0=1, busy=1; rd_addr=2 reads 8'hFF; wr_count=1.
REQ-035 req0=req1=1, addr0=1/data0=8'hAA, addr1=1/data1=8'h55 right after reset -> gnt0 first, then gnt1 two cycles later; r1 final 8'h55, wr_count=2.
REQ-036 Both requesters held high continuously for 8 cycles -> gnt alternates 0,1,0,1 on every other cycle; never both high.
REQ-037 clr asserted in ACK cycle after req1 write of 8'h3C to r3 -> next cycle gnt1=0, busy=0, r3=8'h00, wr_count=0.
REQ-038 300 single writes from requester 0 -> wr_count saturates at 8'hFF.
